// File: rtl/tx_channel_arbiter.sv
// tx_channel_arbiter
// Merges the AW (write-request) and AR (read-request) packet streams into a
// single TX stream. Whole packets are granted one at a time with round-robin
// fairness between the two sources, and a 2-entry skid buffer drives the
// merged output from flops.
//
// Ports
//   clk, resetn            : rising-edge clock, asynchronous active-low reset
//   aw_channel*            : write-request packet stream in, aw_channel_ready out
//   ar_channel*            : read-request packet stream in, ar_channel_ready out
//   dout*, dout_src        : merged stream out (dout_src 0 = AW, 1 = AR)
//   dout_valid, dout_ready : merged stream handshake
//   aw_pkt_cnt, ar_pkt_cnt : wrapping count of packets accepted per source
module tx_channel_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [127:0]     aw_channel,
  input  logic [15:0]      aw_channel_keep,
  input  logic             aw_channel_last,
  input  logic [3:0]       aw_channel_connection_id,
  input  logic [12:0]      aw_channel_byte_num,
  input  logic             aw_channel_valid,
  output logic             aw_channel_ready,
  input  logic [127:0]     ar_channel,
  input  logic [15:0]      ar_channel_keep,
  input  logic             ar_channel_last,
  input  logic [3:0]       ar_channel_connection_id,
  input  logic [12:0]      ar_channel_byte_num,
  input  logic             ar_channel_valid,
  output logic             ar_channel_ready,
  output logic [127:0]     dout,
  output logic [15:0]      dout_keep,
  output logic             dout_last,
  output logic [3:0]       dout_connection_id,
  output logic [12:0]      dout_byte_num,
  output logic             dout_src,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] aw_pkt_cnt,
  output logic [CNT_W-1:0] ar_pkt_cnt
);

  // A beat is carried as {src, data, keep, last, connection_id, byte_num}.
  localparam int BEAT_W = 163;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_AW = 2'd1;
  localparam logic [1:0] BUSY_AR = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [1:0]        state_q, state_d;
  logic              prio_q, prio_d;        // 0 = AW holds priority, 1 = AR
  logic              rdy_en_q, rdy_en_d;    // keeps ready low until the first edge after reset
  logic [1:0]        occ_q, occ_d;          // skid buffer occupancy, 0..2
  logic [BEAT_W-1:0] head_q, head_d;        // entry presented on dout
  logic [BEAT_W-1:0] skid_q, skid_d;        // second entry, filled only under stall
  logic              dout_valid_q, dout_valid_d;
  logic [CNT_W-1:0]  aw_cnt_q, aw_cnt_d;
  logic [CNT_W-1:0]  ar_cnt_q, ar_cnt_d;

  logic              grant_ar_s;
  logic              sel_valid_s;
  logic              sel_last_s;
  logic              can_accept_s;
  logic              in_fire_s;
  logic              out_fire_s;
  logic [BEAT_W-1:0] in_beat_s;

  // Grant selection: locked while a packet is in flight, round-robin in IDLE.
  always_comb begin
    grant_ar_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (aw_channel_valid && ar_channel_valid) begin
          grant_ar_s = prio_q;
        end else if (ar_channel_valid) begin
          grant_ar_s = 1'b1;
        end else if (aw_channel_valid) begin
          grant_ar_s = 1'b0;
        end else begin
          grant_ar_s = prio_q;
        end
      end
      BUSY_AW: grant_ar_s = 1'b0;
      BUSY_AR: grant_ar_s = 1'b1;
      default: grant_ar_s = 1'b0;
    endcase
  end

  // Input handshake and selected-beat mux.
  always_comb begin
    can_accept_s = rdy_en_q && (occ_q != 2'd2);
    sel_valid_s  = grant_ar_s ? ar_channel_valid : aw_channel_valid;
    sel_last_s   = grant_ar_s ? ar_channel_last : aw_channel_last;
    in_fire_s    = sel_valid_s && can_accept_s;
    out_fire_s   = dout_valid_q && dout_ready;
    if (grant_ar_s) begin
      in_beat_s = {1'b1, ar_channel, ar_channel_keep, ar_channel_last,
                   ar_channel_connection_id, ar_channel_byte_num};
    end else begin
      in_beat_s = {1'b0, aw_channel, aw_channel_keep, aw_channel_last,
                   aw_channel_connection_id, aw_channel_byte_num};
    end
  end

  assign aw_channel_ready = can_accept_s && !grant_ar_s;
  assign ar_channel_ready = can_accept_s && grant_ar_s;

  // Packet FSM, priority pointer and packet counters.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    aw_cnt_d = aw_cnt_q;
    ar_cnt_d = ar_cnt_q;
    rdy_en_d = 1'b1;
    // Every accepted last beat hands priority to the other source.
    if (in_fire_s && sel_last_s) begin
      prio_d = ~grant_ar_s;
      if (grant_ar_s) begin
        ar_cnt_d = ar_cnt_q + CNT_ONE;
      end else begin
        aw_cnt_d = aw_cnt_q + CNT_ONE;
      end
    end else begin
      prio_d = prio_q;
    end
    case (state_q)
      IDLE: begin
        // A single-beat packet never leaves IDLE.
        if (in_fire_s && !sel_last_s) begin
          state_d = grant_ar_s ? BUSY_AR : BUSY_AW;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_AW, BUSY_AR: begin
        if (in_fire_s && sel_last_s) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-entry skid buffer: head feeds dout, skid only fills when head stalls.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    case (occ_q)
      2'd0: begin
        if (in_fire_s) begin
          head_d = in_beat_s;
          occ_d  = 2'd1;
        end else begin
          occ_d = 2'd0;
        end
      end
      2'd1: begin
        if (out_fire_s && in_fire_s) begin
          head_d = in_beat_s;
        end else if (out_fire_s) begin
          occ_d = 2'd0;
        end else if (in_fire_s) begin
          skid_d = in_beat_s;
          occ_d  = 2'd2;
        end else begin
          occ_d = 2'd1;
        end
      end
      2'd2: begin
        // Input ready is low here, so only a drain can happen.
        if (out_fire_s) begin
          head_d = skid_q;
          occ_d  = 2'd1;
        end else begin
          occ_d = 2'd2;
        end
      end
      default: occ_d = 2'd0;
    endcase
    dout_valid_d = (occ_d != 2'd0);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      rdy_en_q     <= 1'b0;
      occ_q        <= 2'd0;
      head_q       <= '0;
      skid_q       <= '0;
      dout_valid_q <= 1'b0;
      aw_cnt_q     <= '0;
      ar_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      rdy_en_q     <= rdy_en_d;
      occ_q        <= occ_d;
      head_q       <= head_d;
      skid_q       <= skid_d;
      dout_valid_q <= dout_valid_d;
      aw_cnt_q     <= aw_cnt_d;
      ar_cnt_q     <= ar_cnt_d;
    end
  end

  assign dout_src           = head_q[162];
  assign dout               = head_q[161:34];
  assign dout_keep          = head_q[33:18];
  assign dout_last          = head_q[17];
  assign dout_connection_id = head_q[16:13];
  assign dout_byte_num      = head_q[12:0];
  assign dout_valid         = dout_valid_q;
  assign aw_pkt_cnt         = aw_cnt_q;
  assign ar_pkt_cnt         = ar_cnt_q;

endmodule

// File: tb/tb_tx_channel_arbiter.sv
module tb_tx_channel_arbiter;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic         src;
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic [3:0]   id;
    logic [12:0]  bnum;
  } beat_t;

  logic             clk = 1'b0;
  logic             resetn;
  logic [127:0]     aw_channel, ar_channel, dout;
  logic [15:0]      aw_channel_keep, ar_channel_keep, dout_keep;
  logic             aw_channel_last, ar_channel_last, dout_last;
  logic [3:0]       aw_channel_connection_id, ar_channel_connection_id, dout_connection_id;
  logic [12:0]      aw_channel_byte_num, ar_channel_byte_num, dout_byte_num;
  logic             aw_channel_valid, ar_channel_valid, aw_channel_ready, ar_channel_ready;
  logic             dout_src, dout_valid, dout_ready;
  logic [CNT_W-1:0] aw_pkt_cnt, ar_pkt_cnt;

  always #5 clk = ~clk;

  tx_channel_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .aw_channel(aw_channel), .aw_channel_keep(aw_channel_keep),
    .aw_channel_last(aw_channel_last), .aw_channel_connection_id(aw_channel_connection_id),
    .aw_channel_byte_num(aw_channel_byte_num), .aw_channel_valid(aw_channel_valid),
    .aw_channel_ready(aw_channel_ready),
    .ar_channel(ar_channel), .ar_channel_keep(ar_channel_keep),
    .ar_channel_last(ar_channel_last), .ar_channel_connection_id(ar_channel_connection_id),
    .ar_channel_byte_num(ar_channel_byte_num), .ar_channel_valid(ar_channel_valid),
    .ar_channel_ready(ar_channel_ready),
    .dout(dout), .dout_keep(dout_keep), .dout_last(dout_last),
    .dout_connection_id(dout_connection_id), .dout_byte_num(dout_byte_num),
    .dout_src(dout_src), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .aw_pkt_cnt(aw_pkt_cnt), .ar_pkt_cnt(ar_pkt_cnt)
  );

  // Reference state: pending input beats, expected output order, packet counts,
  // round-robin pointer, and beats held inside the DUT (accepted minus emitted).
  beat_t aw_q[$], ar_q[$], exp_q[$];
  int    total = 0, bad = 0;
  int    cnt_aw = 0, cnt_ar = 0, occ_m = 0;
  bit    prio_m = 1'b0, aw_mid = 1'b0, ar_mid = 1'b0;

  task automatic chk(input string tag, input logic [162:0] obs, input logic [162:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t rand_beat(input bit src, input bit last);
    beat_t b;
    b.src  = src;
    b.data = {$urandom(), $urandom(), $urandom(), $urandom()};
    b.keep = 16'($urandom());
    b.last = last;
    b.id   = 4'($urandom());
    b.bnum = 13'($urandom());
    return b;
  endfunction

  function automatic beat_t cur_beat();
    return {dout_src, dout, dout_keep, dout_last, dout_connection_id, dout_byte_num};
  endfunction

  task automatic add_pkt(input bit src, input int len);
    for (int i = 0; i < len; i++) begin
      if (src) ar_q.push_back(rand_beat(1'b1, i == len - 1));
      else     aw_q.push_back(rand_beat(1'b0, i == len - 1));
    end
  endtask

  task automatic drive_aw(input beat_t b, input logic v);
    aw_channel = b.data; aw_channel_keep = b.keep; aw_channel_last = b.last;
    aw_channel_connection_id = b.id; aw_channel_byte_num = b.bnum; aw_channel_valid = v;
  endtask

  task automatic drive_ar(input beat_t b, input logic v);
    ar_channel = b.data; ar_channel_keep = b.keep; ar_channel_last = b.last;
    ar_channel_connection_id = b.id; ar_channel_byte_num = b.bnum; ar_channel_valid = v;
  endtask

  // Whole-packet round robin over the pending queues gives the output order.
  task automatic build_exp();
    int ia = 0, ir = 0;
    bit p = prio_m, pick;
    beat_t b;
    exp_q.delete();
    while (ia < aw_q.size() || ir < ar_q.size()) begin
      if (ia < aw_q.size() && ir < ar_q.size()) pick = p;
      else pick = (ir < ar_q.size());
      forever begin
        if (pick) begin b = ar_q[ir]; ir++; end
        else begin b = aw_q[ia]; ia++; end
        exp_q.push_back(b);
        if (b.last) break;
      end
      p = ~pick;
    end
  endtask

  // Cycle loop, entered and left at a falling edge.
  // rdy_mode: 0 always ready, 1 random, 2 stalled on cycles 1..5.
  task automatic run(input int rdy_mode, input int gap_pct, input int stop_after_in,
                     input int budget, output int max_occ);
    int cyc = 0, nin = 0, occ0;
    bit prev_stall = 1'b0, expect_new = 1'b0, aw_f, ar_f, out_f;
    beat_t prev_beat, new_beat, b;
    max_occ = 0;
    build_exp();
    while (cyc < budget) begin
      chk("aw_pkt_cnt", 163'(aw_pkt_cnt), 163'(cnt_aw));
      chk("ar_pkt_cnt", 163'(ar_pkt_cnt), 163'(cnt_ar));
      if (exp_q.size() == 0 && aw_q.size() == 0 && ar_q.size() == 0) break;
      if (stop_after_in > 0 && nin >= stop_after_in) break;
      if (aw_q.size() > 0) drive_aw(aw_q[0], !aw_mid || ($urandom_range(99) >= gap_pct));
      else drive_aw(rand_beat(1'b0, 1'b0), 1'b0);
      if (ar_q.size() > 0) drive_ar(ar_q[0], !ar_mid || ($urandom_range(99) >= gap_pct));
      else drive_ar(rand_beat(1'b1, 1'b0), 1'b0);
      if (rdy_mode == 0) dout_ready = 1'b1;
      else if (rdy_mode == 1) dout_ready = 1'($urandom_range(1));
      else dout_ready = (cyc >= 1 && cyc <= 5) ? 1'b0 : 1'b1;
      #1;
      occ0 = occ_m;
      if (prev_stall) begin
        chk("hold_valid", 163'(dout_valid), 163'(1));
        chk("hold_beat", cur_beat(), prev_beat);
      end
      if (expect_new) begin
        chk("latency_valid", 163'(dout_valid), 163'(1));
        chk("latency_beat", cur_beat(), new_beat);
      end
      if (occ0 == 2) begin
        chk("full_aw_ready", 163'(aw_channel_ready), 163'(0));
        chk("full_ar_ready", 163'(ar_channel_ready), 163'(0));
      end
      if (aw_mid) chk("locked_ar_ready", 163'(ar_channel_ready), 163'(0));
      if (ar_mid) chk("locked_aw_ready", 163'(aw_channel_ready), 163'(0));
      if (aw_mid && aw_channel_valid && occ0 < 2) chk("mid_aw_ready", 163'(aw_channel_ready), 163'(1));
      if (ar_mid && ar_channel_valid && occ0 < 2) chk("mid_ar_ready", 163'(ar_channel_ready), 163'(1));
      if (!aw_mid && !ar_mid && occ0 < 2) begin
        if (aw_channel_valid && ar_channel_valid) begin
          if (prio_m) chk("rr_aw_ready", 163'(aw_channel_ready), 163'(0));
          else chk("rr_ar_ready", 163'(ar_channel_ready), 163'(0));
        end else if (aw_channel_valid) begin
          chk("solo_aw_ready", 163'(aw_channel_ready), 163'(1));
        end else if (ar_channel_valid) begin
          chk("solo_ar_ready", 163'(ar_channel_ready), 163'(1));
        end
      end
      out_f = dout_valid && dout_ready;
      aw_f  = aw_channel_valid && aw_channel_ready;
      ar_f  = ar_channel_valid && ar_channel_ready;
      if (out_f) begin
        chk("beat_expected", 163'(exp_q.size() > 0), 163'(1));
        if (exp_q.size() > 0) begin
          chk("out_beat", cur_beat(), exp_q[0]);
          void'(exp_q.pop_front());
        end
        occ_m--;
      end
      chk("single_grant", 163'(aw_f && ar_f), 163'(0));
      expect_new = 1'b0;
      if (aw_f || ar_f) begin
        if (aw_f) b = aw_q.pop_front();
        else b = ar_q.pop_front();
        if (occ0 == 0) begin expect_new = 1'b1; new_beat = b; end
        occ_m++;
        nin++;
        if (b.last) begin
          if (aw_f) begin cnt_aw = (cnt_aw + 1) % 16; aw_mid = 1'b0; prio_m = 1'b1; end
          else begin cnt_ar = (cnt_ar + 1) % 16; ar_mid = 1'b0; prio_m = 1'b0; end
        end else begin
          if (aw_f) aw_mid = 1'b1;
          else ar_mid = 1'b1;
        end
      end
      if (occ_m > max_occ) max_occ = occ_m;
      prev_stall = dout_valid && !dout_ready;
      prev_beat  = cur_beat();
      cyc++;
      @(negedge clk);
    end
    if (stop_after_in == 0) chk("drained", 163'(exp_q.size()), 163'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    int mo;
    logic [CNT_W-1:0] a0, r0;

    // Reset state with both sources asserting valid.
    resetn = 1'b0;
    dout_ready = 1'b1;
    drive_aw(rand_beat(1'b0, 1'b1), 1'b1);
    drive_ar(rand_beat(1'b1, 1'b1), 1'b1);
    repeat (3) @(negedge clk);
    chk("rst_dout_valid", 163'(dout_valid), 163'(0));
    chk("rst_aw_ready", 163'(aw_channel_ready), 163'(0));
    chk("rst_ar_ready", 163'(ar_channel_ready), 163'(0));
    chk("rst_dout", cur_beat(), 163'(0));
    chk("rst_aw_cnt", 163'(aw_pkt_cnt), 163'(0));
    chk("rst_ar_cnt", 163'(ar_pkt_cnt), 163'(0));

    // Single AR beat; ready must wait for the first edge after release.
    drive_aw(rand_beat(1'b0, 1'b0), 1'b0);
    b = rand_beat(1'b1, 1'b1);
    b.keep = 16'h07ff; b.id = 4'd3; b.bnum = 13'h00b;
    ar_q.push_back(b);
    drive_ar(b, 1'b1);
    resetn = 1'b1;
    #1;
    chk("ready_before_edge", 163'(ar_channel_ready), 163'(0));
    @(negedge clk);
    run(0, 0, 0, 20, mo);
    chk("single_ar_cnt", 163'(ar_pkt_cnt), 163'(1));

    // Contention: 4-beat AW and 1-beat AR both pending.
    add_pkt(1'b0, 4);
    add_pkt(1'b1, 1);
    run(0, 0, 0, 40, mo);

    // Fairness: ten 1-beat packets alternate.
    a0 = aw_pkt_cnt; r0 = ar_pkt_cnt;
    for (int i = 0; i < 5; i++) begin add_pkt(1'b0, 1); add_pkt(1'b1, 1); end
    run(0, 0, 0, 60, mo);
    chk("fair_aw_delta", 163'(CNT_W'(aw_pkt_cnt - a0)), 163'(5));
    chk("fair_ar_delta", 163'(CNT_W'(ar_pkt_cnt - r0)), 163'(5));

    // Backpressure: 6-beat AW packet, output stalled for 5 cycles.
    add_pkt(1'b0, 6);
    run(2, 0, 0, 60, mo);
    chk("bp_max_buffered", 163'(mo), 163'(2));

    // Randomized traffic.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < int'($urandom_range(4, 1)); k++) add_pkt(1'b0, int'($urandom_range(5, 1)));
      for (int k = 0; k < int'($urandom_range(4, 1)); k++) add_pkt(1'b1, int'($urandom_range(5, 1)));
      run((r % 3 == 0) ? 0 : 1, 30, 0, 2000, mo);
    end

    // Reset mid-packet after two beats of a 4-beat AW packet.
    add_pkt(1'b0, 4);
    run(0, 0, 2, 40, mo);
    resetn = 1'b0;
    #1;
    chk("midrst_dout_valid", 163'(dout_valid), 163'(0));
    chk("midrst_aw_cnt", 163'(aw_pkt_cnt), 163'(0));
    chk("midrst_ar_cnt", 163'(ar_pkt_cnt), 163'(0));
    chk("midrst_aw_ready", 163'(aw_channel_ready), 163'(0));
    chk("midrst_dout", cur_beat(), 163'(0));
    aw_q.delete(); ar_q.delete(); exp_q.delete();
    cnt_aw = 0; cnt_ar = 0; occ_m = 0;
    prio_m = 1'b0; aw_mid = 1'b0; ar_mid = 1'b0;
    drive_aw(rand_beat(1'b0, 1'b0), 1'b0);
    drive_ar(rand_beat(1'b1, 1'b0), 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    add_pkt(1'b1, 2);
    run(1, 20, 0, 200, mo);
    chk("post_rst_ar_cnt", 163'(ar_pkt_cnt), 163'(1));

    // Counter wrap: 17 AW packets on a 4-bit counter.
    for (int i = 0; i < 17; i++) add_pkt(1'b0, int'($urandom_range(3, 1)));
    run(1, 20, 0, 1000, mo);
    chk("wrap_aw_cnt", 163'(aw_pkt_cnt), 163'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
